dmem_mmio_responder: RTL and testbench

Responder side of the CPU data-access interface. Accepts one load/store request at a time from the CPU datapath, decodes the address into data RAM or MMIO (LEDs, switches), and applies RV32I byte/half/word sizing with sign or zero extension. Returns read data or an error with a valid pulse after a programmable number of wait states. Sits between the CPU top and the board I/O.

---
 rtl/dmem_mmio_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_responder
// Description : Responder for CPU data-memory accesses. Decodes each request
//               into data RAM, the LED register or the switch register,
//               applies RV32I byte/half/word sizing with sign/zero extension
//               and answers with a one-cycle resp_valid pulse after
//               WAIT_CYCLES wait states.
//               Optional build macro MMIO_TIMER_EN adds a read-only
//               free-running cycle counter at 32'hFFFF_FC40.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] LED_ADDR    = 32'hFFFF_FC60,
    parameter logic [31:0] SW_ADDR     = 32'hFFFF_FC70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [15:0] switches,
    output logic [15:0] leds
);

    localparam int          c_aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_ram_bytes = 32'(DEPTH * 4);
    localparam logic [3:0]  c_last      = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic        c_no_wait   = (WAIT_CYCLES == 0);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [15:0] r_leds;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_wr;
    logic [31:0] w_a;
    logic [31:0] w_wd;
    logic [2:0]  w_f3;
    logic        w_legal;
    logic        w_mis;
    logic        w_hit_ram;
    logic        w_hit_led;
    logic        w_hit_sw;
    logic        w_hit_tmr;
    logic [31:0] w_tmr_val;
    logic        w_err;
    logic [c_aw-1:0] w_idx;
    logic [31:0] w_rword;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wlane;
    logic        w_commit;

    assign req_ready  = (r_state == c_st_idle) && !rst;
    assign resp_valid = (r_state == c_st_resp);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign leds       = r_leds;

    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = ((r_state == c_st_idle) && w_accept && c_no_wait) ||
                          ((r_state == c_st_wait) && (r_cnt == c_last));

    // With zero wait states the access happens on the accept edge, so the
    // live request is used instead of the (not yet loaded) latched copy.
    assign w_wr = (r_state == c_st_idle) ? req_write  : r_write;
    assign w_a  = (r_state == c_st_idle) ? req_addr   : r_addr;
    assign w_wd = (r_state == c_st_idle) ? req_wdata  : r_wdata;
    assign w_f3 = (r_state == c_st_idle) ? req_funct3 : r_funct3;

`ifdef MMIO_TIMER_EN
    localparam logic [31:0] c_tmr_addr = 32'hFFFF_FC40;
    logic [31:0] r_timer;

    // Free-running cycle counter visible as a read-only MMIO register
    always_ff @(posedge clk) begin
        if (rst) r_timer <= '0;
        else     r_timer <= r_timer + 32'd1;
    end

    assign w_hit_tmr = (w_a[31:2] == c_tmr_addr[31:2]);
    assign w_tmr_val = r_timer;
`else
    assign w_hit_tmr = 1'b0;
    assign w_tmr_val = 32'd0;
`endif

    // Address decode and error classification
    assign w_legal   = w_wr ? (w_f3 inside {3'b000, 3'b001, 3'b010})
                            : (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_mis     = ((w_f3[1:0] == 2'b01) && w_a[0]) ||
                       ((w_f3[1:0] == 2'b10) && (w_a[1:0] != 2'b00));
    assign w_hit_ram = (w_a < c_ram_bytes);
    assign w_hit_led = (w_a[31:2] == LED_ADDR[31:2]);
    assign w_hit_sw  = (w_a[31:2] == SW_ADDR[31:2]);
    assign w_err     = !w_legal || w_mis ||
                       !(w_hit_ram || w_hit_led || w_hit_sw || w_hit_tmr);
    assign w_idx     = w_a[c_aw+1:2];
    assign w_commit  = w_enter_resp && !rst && w_wr && !w_err;

    // Read word selection and load extraction (little-endian lanes)
    always_comb begin
        w_rword = 32'd0;
        if (w_hit_ram)      w_rword = r_mem[w_idx];
        else if (w_hit_led) w_rword = {16'd0, r_leds};
        else if (w_hit_sw)  w_rword = {16'd0, r_sw_sync};
        else if (w_hit_tmr) w_rword = w_tmr_val;
        w_shift = w_rword >> {w_a[1:0], 3'b000};
        case (w_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = w_shift;
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = 32'd0;
        endcase
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        case (w_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_a[1:0];
                w_wlane = {4{w_wd[7:0]}};
            end
            2'b01: begin
                w_be    = w_a[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_wd[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = w_wd;
            end
        endcase
    end

    // Data RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_commit && w_hit_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    // LED register: only lanes 0 and 1 overlap its 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
        end else if (w_commit && w_hit_led) begin
            if (w_be[0]) r_leds[7:0]  <= w_wlane[7:0];
            if (w_be[1]) r_leds[15:8] <= w_wlane[15:8];
        end
    end

    // Two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Response registers, loaded on the edge entering RESP and held after
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= (w_err || w_wr) ? 32'd0 : w_load;
            r_err   <= w_err;
        end
    end

    // Request sequencing: IDLE -> WAIT -> RESP -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_write  <= req_write;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_cnt    <= '0;
                        r_state  <= c_no_wait ? c_st_resp : c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_cnt == c_last) r_state <= c_st_resp;
                    else                 r_cnt   <= r_cnt + 4'd1;
                end
                c_st_resp: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_mmio_responder
// Description : Self-checking bench for dmem_mmio_responder. A transaction
//               level model predicts every response, req_ready and leds on
//               every cycle; directed requests also carry literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

    localparam int          DEPTH       = 1024;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] LED_ADDR    = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR     = 32'hFFFF_FC70;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] switches;
    logic [15:0] leds;

    dmem_mmio_responder #(
        .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .LED_ADDR(LED_ADDR), .SW_ADDR(SW_ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .switches(switches), .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        int          acc;
        int          due;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    txn_t        q[$];
    logic [31:0] mem [int];
    logic [15:0] mleds = '0;
    logic [31:0] m_last_rd;
    logic        m_last_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous reset in the model: abort pending work, clear LEDs
    always @(posedge clk) begin
        if (rst) begin
            mleds = '0;
            q.delete();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Architectural effect of one access, straight from the access rules
    function automatic void model_access(input txn_t t, output logic [31:0] rd,
                                         output logic e, output logic skip);
        int          off;
        int          nbytes;
        logic        legal;
        logic        is_ram, is_led, is_sw, is_tmr;
        logic [31:0] word;
        off    = int'(t.a[1:0]);
        nbytes = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
        legal  = t.w ? (t.f3 <= 3'd2) : (t.f3 != 3'd3 && t.f3 <= 3'd5);
        is_ram = longint'(t.a) < longint'(DEPTH) * 4;
        is_led = (t.a & ~32'h3) == LED_ADDR;
        is_sw  = (t.a & ~32'h3) == SW_ADDR;
`ifdef MMIO_TIMER_EN
        is_tmr = (t.a & ~32'h3) == 32'hFFFF_FC40;
`else
        is_tmr = 1'b0;
`endif
        skip = 1'b0;
        rd   = 32'd0;
        e    = !legal || (off % nbytes != 0) || !(is_ram || is_led || is_sw || is_tmr);
        if (e) return;
        if (is_tmr) begin
            skip = 1'b1;
            return;
        end
        word = is_ram ? mem[int'(t.a >> 2)] : is_led ? {16'd0, mleds} : {16'd0, switches};
        if (t.w) begin
            for (int i = 0; i < nbytes; i++) word[8*(off+i) +: 8] = t.wd[8*i +: 8];
            if (is_ram) mem[int'(t.a >> 2)] = word;
            if (is_led) mleds = word[15:0];
        end else begin
            word = word >> (8 * off);
            if (nbytes == 1)      rd = {{24{word[7]  & ~t.f3[2]}}, word[7:0]};
            else if (nbytes == 2) rd = {{16{word[15] & ~t.f3[2]}}, word[15:0]};
            else                  rd = word;
        end
    endfunction

    // Per-cycle comparison of every DUT output against the model
    logic        c_busy, c_exp_valid, c_e, c_skip;
    logic [31:0] c_rd;
    always begin
        @(negedge clk);
        #1;
        c_busy      = q.size() > 0 && cyc >= q[0].acc && cyc <= q[0].due;
        c_exp_valid = q.size() > 0 && cyc == q[0].due && !rst;
        chk("req_ready", {31'd0, req_ready}, {31'd0, !rst && !c_busy});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, c_exp_valid});
        if (c_exp_valid) begin
            model_access(q[0], c_rd, c_e, c_skip);
            m_last_rd  = c_rd;
            m_last_err = c_e;
            void'(q.pop_front());
            chk("resp_err", {31'd0, resp_err}, {31'd0, c_e});
            if (!c_skip) chk("resp_rdata", resp_rdata, c_rd);
        end else if (q.size() > 0 && cyc > q[0].due) begin
            void'(q.pop_front());
        end
        chk("leds", {16'd0, leds}, {16'd0, mleds});
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // One request held for 'hold' cycles; response checked against literals
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int hold,
                          input logic [31:0] lit_rd, input logic lit_err);
        txn_t t;
        int   n = 0;
        wait_ready();
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        t = '{w: w, a: a, wd: wd, f3: f3, acc: cyc + 1, due: cyc + 1 + WAIT_CYCLES};
        q.push_back(t);
        repeat (hold) @(negedge clk);
        req_valid = 1'b0;
        while (cyc <= t.due && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("lit_rdata", resp_rdata, lit_rd);
        chk("lit_err", {31'd0, resp_err}, {31'd0, lit_err});
        chk("model_rdata", m_last_rd, lit_rd);
        chk("model_err", {31'd0, m_last_err}, {31'd0, lit_err});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        txn_t t;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        switches   = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
        chk("reset_leds", {16'd0, leds}, 32'd0);
        rst = 1'b0;

        // Word store/load and sub-word loads
        do_req(1'b1, 32'h10, 32'h8000_00F1, 3'b010, 1, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0,         3'b010, 1, 32'h8000_00F1, 1'b0);
        do_req(1'b0, 32'h13, 32'h0,         3'b000, 1, 32'hFFFF_FF80, 1'b0);
        do_req(1'b0, 32'h13, 32'h0,         3'b100, 1, 32'h0000_0080, 1'b0);
        do_req(1'b0, 32'h12, 32'h0,         3'b001, 1, 32'hFFFF_8000, 1'b0);
        do_req(1'b0, 32'h10, 32'h0,         3'b101, 1, 32'h0000_00F1, 1'b0);
        do_req(1'b1, 32'h11, 32'h0000_00AA, 3'b000, 1, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0,         3'b010, 1, 32'h8000_AAF1, 1'b0);

        // Misaligned, unmapped and illegal-funct3 accesses
        do_req(1'b0, 32'h2,  32'h0,         3'b010, 1, 32'h0, 1'b1);
        do_req(1'b1, 32'h4,  32'hDEAD_BEEF, 3'b010, 1, 32'h0, 1'b0);
        do_req(1'b1, 32'h5,  32'h0000_1111, 3'b001, 1, 32'h0, 1'b1);
        do_req(1'b0, 32'h4,  32'h0,         3'b010, 1, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h0001_0000, 32'h0,  3'b010, 1, 32'h0, 1'b1);
        do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 3'b100, 1, 32'h0, 1'b1);
        do_req(1'b0, 32'h10, 32'h0,         3'b011, 1, 32'h0, 1'b1);

        // req_valid held through the busy period must give one response only
        do_req(1'b0, 32'h10, 32'h0,         3'b010, 4, 32'h8000_AAF1, 1'b0);

        // RAM upper boundary
        do_req(1'b1, 32'h0FFC, 32'hCAFE_F00D, 3'b010, 1, 32'h0, 1'b0);
        do_req(1'b0, 32'h0FFE, 32'h0,         3'b001, 1, 32'hFFFF_CAFE, 1'b0);
        do_req(1'b0, 32'h1000, 32'h0,         3'b010, 1, 32'h0, 1'b1);

        // LED register
        do_req(1'b1, LED_ADDR, 32'h1234_5678, 3'b010, 1, 32'h0, 1'b0);
        chk("leds_after_sw", {16'd0, leds}, 32'h0000_5678);
        do_req(1'b1, LED_ADDR + 32'd2, 32'h0000_FFFF, 3'b001, 1, 32'h0, 1'b0);
        do_req(1'b0, LED_ADDR + 32'd1, 32'h0, 3'b000, 1, 32'h0000_0056, 1'b0);
        do_req(1'b1, LED_ADDR, 32'h0000_0080, 3'b000, 1, 32'h0, 1'b0);
        do_req(1'b0, LED_ADDR, 32'h0, 3'b000, 1, 32'hFFFF_FF80, 1'b0);
        chk("leds_after_sb", {16'd0, leds}, 32'h0000_5680);

        // Switch register through the synchronizer
        switches = 16'h00C3;
        repeat (4) @(negedge clk);
        do_req(1'b0, SW_ADDR, 32'h0, 3'b010, 1, 32'h0000_00C3, 1'b0);
        do_req(1'b1, SW_ADDR, 32'hFFFF_FFFF, 3'b010, 1, 32'h0, 1'b0);
        do_req(1'b0, SW_ADDR, 32'h0, 3'b101, 1, 32'h0000_00C3, 1'b0);

`ifndef MMIO_TIMER_EN
        do_req(1'b0, 32'hFFFF_FC40, 32'h0, 3'b010, 1, 32'h0, 1'b1);
`endif

        // Reset during the wait states of a store aborts it
        do_req(1'b1, 32'h20, 32'h1111_1111, 3'b010, 1, 32'h0, 1'b0);
        wait_ready();
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h2222_2222;
        req_funct3 = 3'b010;
        t = '{w: 1'b1, a: 32'h20, wd: 32'h2222_2222, f3: 3'b010, acc: cyc + 1, due: cyc + 1 + WAIT_CYCLES};
        q.push_back(t);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        chk("leds_after_rst", {16'd0, leds}, 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 3'b010, 1, 32'h1111_1111, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
